// File: rtl/nand_logic_unit_if.sv
// nand_logic_unit_if: request/result bus of the NAND logic unit.
// master = stimulus side (drives requests, consumes results),
// slave  = the logic unit itself.
interface nand_logic_unit_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  logic                     in_valid;
  logic                     in_ready;
  logic [2:0]               op;
  logic [WIDTH-1:0]         a;
  logic [WIDTH-1:0]         b;
  logic                     out_valid;
  logic                     out_ready;
  logic [WIDTH-1:0]         y;
  logic [$clog2(DEPTH):0]   count;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, y, count
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, y, count
  );
endinterface

// File: rtl/nand_logic_unit.sv
// nand_logic_unit: registered multi-function bitwise logic unit.
// Every function is composed purely from 2-input NAND gates. Requests are
// accepted over a valid/ready handshake and results queue in a DEPTH-entry
// FIFO whose head is presented on y.
// Build option: NLU_REDUCE_EN -- when defined, opcode 111 is the
// reduction-NAND of a; otherwise opcode 111 passes a through.
module nand_logic_unit #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input logic              clk,
  input logic              rst_n,
  nand_logic_unit_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  // The single gate primitive; every function below is a network of it.
  function automatic logic [WIDTH-1:0] nand_v(input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] z);
    return ~(x & z);
  endfunction

  function automatic logic nand_s(input logic x, input logic z);
    return ~(x & z);
  endfunction

`ifdef NLU_REDUCE_EN
  localparam int LVL = $clog2(WIDTH);
  localparam int P2  = 1 << LVL;

  // AND-tree of re-inverted NAND pairs, closed by a final NAND inversion.
  // Unused upper leaves are padded with 1 so they do not affect the AND.
  function automatic logic reduce_nand(input logic [WIDTH-1:0] v);
    logic [P2-1:0] t;
    logic          p;
    t            = {P2{1'b1}};
    t[WIDTH-1:0] = v;
    for (int s = 0; s < LVL; s++) begin
      for (int i = 0; i < P2 / 2; i++) begin
        if (i < (P2 >> (s + 1))) begin
          p    = nand_s(t[2*i], t[2*i+1]);
          t[i] = nand_s(p, p);
        end
      end
    end
    return nand_s(t[0], t[0]);
  endfunction
`endif

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic [WIDTH-1:0] y_r;

  logic             push_s;
  logic             pop_s;
  logic [CW-1:0]    count_next_s;
  logic [PW-1:0]    rd_next_s;
  logic [WIDTH-1:0] y_next_s;
  logic [WIDTH-1:0] result_s;
  logic [WIDTH-1:0] n_ab_s;
  logic [WIDTH-1:0] not_a_s;
  logic [WIDTH-1:0] not_b_s;
  logic [WIDTH-1:0] or_s;
  logic [WIDTH-1:0] xor_s;

  assign push_s = bus.in_valid && in_ready_r;
  assign pop_s  = out_valid_r && bus.out_ready;

  // NAND-network evaluation of the selected function.
  always_comb begin
    n_ab_s   = nand_v(bus.a, bus.b);
    not_a_s  = nand_v(bus.a, bus.a);
    not_b_s  = nand_v(bus.b, bus.b);
    or_s     = nand_v(not_a_s, not_b_s);
    xor_s    = nand_v(nand_v(bus.a, n_ab_s), nand_v(bus.b, n_ab_s));
    result_s = {WIDTH{1'b0}};
    case (bus.op)
      3'b000:  result_s = nand_v(n_ab_s, n_ab_s);
      3'b001:  result_s = or_s;
      3'b010:  result_s = n_ab_s;
      3'b011:  result_s = nand_v(or_s, or_s);
      3'b100:  result_s = xor_s;
      3'b101:  result_s = nand_v(xor_s, xor_s);
      3'b110:  result_s = not_a_s;
`ifdef NLU_REDUCE_EN
      3'b111:  result_s = WIDTH'(reduce_nand(bus.a));
`else
      3'b111:  result_s = nand_v(not_a_s, not_a_s);
`endif
      default: result_s = {WIDTH{1'b0}};
    endcase
  end

  // Occupancy and next head value; y keeps its value once the FIFO empties.
  always_comb begin
    count_next_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + CW'(1);
      2'b01:   count_next_s = count_r - CW'(1);
      default: count_next_s = count_r;
    endcase
    if (pop_s) begin
      rd_next_s = rd_ptr_r + PW'(1);
    end else begin
      rd_next_s = rd_ptr_r;
    end
    if (count_next_s == CW'(0)) begin
      y_next_s = y_r;
    end else if (push_s && (wr_ptr_r == rd_next_s)) begin
      y_next_s = result_s;
    end else begin
      y_next_s = mem_r[rd_next_s];
    end
  end

  // FIFO storage, pointers, occupancy and registered output flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_r    <= {PW{1'b0}};
      rd_ptr_r    <= {PW{1'b0}};
      count_r     <= {CW{1'b0}};
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      y_r         <= {WIDTH{1'b0}};
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= result_s;
        wr_ptr_r        <= wr_ptr_r + PW'(1);
      end
      rd_ptr_r    <= rd_next_s;
      count_r     <= count_next_s;
      in_ready_r  <= (count_next_s != CW'(DEPTH));
      out_valid_r <= (count_next_s != CW'(0));
      y_r         <= y_next_s;
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.y         = y_r;
  assign bus.count     = count_r;
endmodule

// File: tb/tb_nand_logic_unit.sv
// tb_nand_logic_unit: directed and randomized checks of nand_logic_unit
// against a queue-based reference model (WIDTH=8, DEPTH=4).
module tb_nand_logic_unit;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  logic [7:0] model_q [$];

  nand_logic_unit_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  nand_logic_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref_f(input logic [2:0] o, input logic [7:0] x, input logic [7:0] z);
    case (o)
      3'd0: return x & z;
      3'd1: return x | z;
      3'd2: return ~(x & z);
      3'd3: return ~(x | z);
      3'd4: return x ^ z;
      3'd5: return ~(x ^ z);
      3'd6: return ~x;
`ifdef NLU_REDUCE_EN
      default: return {7'd0, ~&x};
`else
      default: return x;
`endif
    endcase
  endfunction

  // One clock cycle: drive request, advance model on the edge, check outputs.
  task automatic step(input logic iv, input logic ordy, input logic [2:0] o,
                      input logic [7:0] av, input logic [7:0] bv);
    bit push;
    bit pop;
    bus.in_valid  = iv;
    bus.out_ready = ordy;
    bus.op        = o;
    bus.a         = av;
    bus.b         = bv;
    push = iv && (model_q.size() < DEPTH);
    pop  = ordy && (model_q.size() > 0);
    @(posedge clk);
    if (pop)  void'(model_q.pop_front());
    if (push) model_q.push_back(ref_f(o, av, bv));
    #1;
    check_eq("count", 32'(bus.count), 32'(model_q.size()));
    check_eq("out_valid", 32'(bus.out_valid), 32'(model_q.size() != 0));
    check_eq("in_ready", 32'(bus.in_ready), 32'(model_q.size() != DEPTH));
    if (model_q.size() != 0) check_eq("y_head", 32'(bus.y), 32'(model_q[0]));
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_count"}, 32'(bus.count), 32'd0);
    check_eq({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    check_eq({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    check_eq({tag, "_y"}, 32'(bus.y), 32'd0);
  endtask

  logic [7:0] sweep_exp [7];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    sweep_exp = '{8'h48, 8'hDE, 8'hB7, 8'h21, 8'h96, 8'h69, 8'h35};
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.op        = 3'd0;
    bus.a         = 8'd0;
    bus.b         = 8'd0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("reset");
    rst_n = 1'b1;

    // Empty pop: out_ready ignored while empty.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 3'd0, 8'h00, 8'h00);

    // Function sweep, back to back with the consumer always ready.
    for (int i = 0; i < 7; i++) begin
      step(1'b1, 1'b1, 3'(i), 8'hCA, 8'h5C);
      check_eq("sweep_y", 32'(bus.y), 32'(sweep_exp[i]));
    end
    step(1'b0, 1'b1, 3'd0, 8'h00, 8'h00);

    // Opcode 111.
    step(1'b1, 1'b1, 3'd7, 8'hFF, 8'h00);
`ifdef NLU_REDUCE_EN
    check_eq("op7_ff", 32'(bus.y), 32'h00);
`else
    check_eq("op7_ff", 32'(bus.y), 32'hFF);
`endif
    step(1'b1, 1'b1, 3'd7, 8'hFE, 8'h33);
`ifdef NLU_REDUCE_EN
    check_eq("op7_fe", 32'(bus.y), 32'h01);
`else
    check_eq("op7_fe", 32'(bus.y), 32'hFE);
`endif
    step(1'b0, 1'b1, 3'd0, 8'h00, 8'h00);

    // Fill and backpressure: five requests, consumer stalled.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 3'(i), 8'(8'h11 * (i + 1)), 8'h0F);
    check_eq("full_count", 32'(bus.count), 32'd4);
    check_eq("full_in_ready", 32'(bus.in_ready), 32'd0);
    // Fifth request held; popping at full must not admit it the same cycle.
    step(1'b1, 1'b1, 3'd4, 8'h55, 8'h0F);
    check_eq("full_pop_count", 32'(bus.count), 32'd3);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 3'd0, 8'h00, 8'h00);
    check_eq("drained", 32'(bus.out_valid), 32'd0);

    // Simultaneous push/pop at count=2 across pointer wrap.
    step(1'b1, 1'b0, 3'd1, 8'h81, 8'h18);
    step(1'b1, 1'b0, 3'd4, 8'h3C, 8'hF0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b1, 3'(i % 8), 8'($urandom), 8'($urandom));
      check_eq("pp_count", 32'(bus.count), 32'd2);
    end
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 3'd0, 8'h00, 8'h00);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
           3'($urandom), 8'($urandom), 8'($urandom));
    end
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 3'd0, 8'h00, 8'h00);

    // Async reset mid-stream at count=3.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 3'd5, 8'(8'h21 + i), 8'h7E);
    check_eq("pre_rst_count", 32'(bus.count), 32'd3);
    bus.in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check_reset_state("async_rst");
    model_q.delete();
    #1 rst_n = 1'b1;
    step(1'b1, 1'b1, 3'd0, 8'hF3, 8'h3F);
    check_eq("post_rst_y", 32'(bus.y), 32'h33);
    step(1'b0, 1'b1, 3'd0, 8'h00, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
